// File: rtl/muldiv_hilo_controller.sv
// muldiv_hilo_controller: iterative radix-2 MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
module muldiv_hilo_controller #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0] rt,
    input  logic                  cancel,
    input  logic                  hi_we,
    input  logic                  lo_we,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int W = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            is_div, sa, sb, dz;
    logic [W-1:0]    b;
    logic [2*W-1:0]  acc;

    logic            sgn_op;
    logic [W-1:0]    mag_rs, mag_rt, quo, rem;
    logic [W:0]      mul_sum;
    logic [W+1:0]    div_diff;
    logic [2*W-1:0]  acc_nxt, prod;

    assign sgn_op = ~op[0];
    assign mag_rs = (sgn_op && rs[W-1]) ? -rs : rs;
    assign mag_rt = (sgn_op && rt[W-1]) ? -rt : rt;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, b & {W{acc[0]}}};
        div_diff = {1'b0, acc[2*W-1:W-1]} - {2'b00, b};
        acc_nxt  = !is_div ? {mul_sum, acc[W-1:1]} :
                   div_diff[W+1] ? {acc[2*W-2:0], 1'b0} :
                   {div_diff[W-1:0], acc[W-2:0], 1'b1};
        prod     = (sa ^ sb) ? -acc : acc;
        quo      = dz ? {W{1'b1}} : ((sa ^ sb) ? -acc[W-1:0] : acc[W-1:0]);
        rem      = sa ? -acc[2*W-1:W] : acc[2*W-1:W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            dz     <= 1'b0;
            b      <= '0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start && !cancel) begin
                        state  <= CALC;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        is_div <= op[1];
                        sa     <= sgn_op & rs[W-1];
                        sb     <= sgn_op & rt[W-1];
                        dz     <= op[1] && (rt == '0);
                        b      <= op[1] ? mag_rt : mag_rs;
                        acc    <= {{W{1'b0}}, op[1] ? mag_rs : mag_rt};
                    end
                end
                CALC: begin
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!cancel) begin
                        done     <= 1'b1;
                        {hi, lo} <= is_div ? {rem, quo} : prod;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_hilo_controller.sv
// tb_muldiv_hilo_controller: scoreboard bench; expected HI/LO come from a 64-bit reference model
module tb_muldiv_hilo_controller;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, cancel, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] rs, rt, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic [63:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    muldiv_hilo_controller #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs(rs), .rt(rt),
        .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
        longint x, y;
        x = longint'($signed(a));
        y = longint'($signed(d));
        if (o == 2'b00) return 64'(x * y);
        if (o == 2'b01) return {32'b0, a} * {32'b0, d};
        if (d == 32'b0) return {a, 32'hFFFF_FFFF};
        if (o == 2'b10) return {32'(x % y), 32'(x / y)};
        return {a % d, a / d};
    endfunction

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
        start = 1'b1; op = o; rs = a; rt = d;
        exp_q.push_back(model(o, a, d));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_result(input string name, input int exp_busy);
        int nb, cyc;
        logic [63:0] e;
        nb = 0; cyc = 0; e = 64'hx;
        while (!done && cyc < 100) begin
            if (busy) nb++;
            cyc++;
            @(negedge clk);
        end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL %s: no done pulse within 100 cycles", name); end
        checks++;
        if (nb !== exp_busy) begin errors++; $display("FAIL %s latency: busy cycles %0d, required %0d", name, nb, exp_busy); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s: busy=%b in done cycle, required 0", name, busy); end
        checks++;
        if ({hi, lo} !== e) begin errors++; $display("FAIL %s result: hi/lo=%h_%h, required %h_%h", name, hi, lo, e[63:32], e[31:0]); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; cancel = 0; hi_we = 0; lo_we = 0; op = 0; rs = 0; rt = 0; wdata = 0;
        #1;
        checks++;
        if ({busy, done, hi, lo} !== 66'b0) begin errors++; $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, required all 0", busy, done, hi, lo); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_writes();
        hi_we = 1; lo_we = 1; wdata = 32'h5A5A_0F0F;
        @(negedge clk);
        hi_we = 0; lo_we = 0;
        checks++;
        if ({hi, lo} !== {2{32'h5A5A_0F0F}}) begin errors++; $display("FAIL write_both: hi=%h lo=%h, required 5a5a0f0f both", hi, lo); end
        lo_we = 1; wdata = 32'h0000_1234;
        @(negedge clk);
        lo_we = 0;
        checks++;
        if ({hi, lo} !== {32'h5A5A_0F0F, 32'h0000_1234}) begin errors++; $display("FAIL write_lo: hi=%h lo=%h, required 5a5a0f0f/00001234", hi, lo); end
    endtask

    task automatic test_mult();
        issue(2'b00, 32'd7, 32'hFFFF_FFFD);
        wait_result("mult_7x-3", 33);
        checks++;
        if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB}) begin errors++; $display("FAIL mult_const: hi=%h lo=%h, required ffffffff/ffffffeb", hi, lo); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_width: done=%b one cycle later, required 0", done); end
    endtask

    task automatic test_vectors();
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("multu_max", 33);
        checks++;
        if ({hi, lo} !== {32'hFFFF_FFFE, 32'h0000_0001}) begin errors++; $display("FAIL multu_const: hi=%h lo=%h, required fffffffe/00000001", hi, lo); end
        issue(2'b11, 32'd100, 32'd7);
        wait_result("divu_100_7", 33);
        checks++;
        if ({hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_const: hi=%h lo=%h, required 2/e", hi, lo); end
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_result("div_-7_2", 33);
        checks++;
        if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin errors++; $display("FAIL div_neg_const: hi=%h lo=%h, required ffffffff/fffffffd", hi, lo); end
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("div_min_-1", 33);
        checks++;
        if ({hi, lo} !== {32'h0, 32'h8000_0000}) begin errors++; $display("FAIL div_min_const: hi=%h lo=%h, required 0/80000000", hi, lo); end
        issue(2'b00, 32'h8000_0000, 32'h8000_0000);
        wait_result("mult_min_min", 33);
    endtask

    task automatic test_divzero();
        issue(2'b10, 32'h1234_5678, 32'h0);
        wait_result("div_by_zero", 33);
        checks++;
        if ({hi, lo} !== {32'h1234_5678, 32'hFFFF_FFFF}) begin errors++; $display("FAIL divzero_const: hi=%h lo=%h, required 12345678/ffffffff", hi, lo); end
        issue(2'b10, 32'h8000_0001, 32'h0);
        wait_result("div_neg_by_zero", 33);
        issue(2'b11, 32'hDEAD_BEEF, 32'h0);
        wait_result("divu_by_zero", 33);
    endtask

    task automatic test_busy_inputs();
        issue(2'b01, 32'd5, 32'd6);
        hi_we = 1; wdata = 32'hDEAD_0000; start = 1; op = 2'b11; rs = 32'd9; rt = 32'd3;
        @(negedge clk);
        hi_we = 0; start = 0; lo_we = 1;
        @(negedge clk);
        lo_we = 0;
        wait_result("busy_inputs_ignored", 31);
    endtask

    task automatic test_cancel();
        logic [31:0] lo_before;
        logic        saw_done;
        hi_we = 1; wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        hi_we = 0;
        checks++;
        if (hi !== 32'hA5A5_A5A5) begin errors++; $display("FAIL preload: hi=%h, required a5a5a5a5", hi); end
        lo_before = lo;
        start = 1; op = 2'b00; rs = 32'd123; rt = 32'd456;
        @(negedge clk);
        start = 0;
        for (int i = 1; i < 10; i++) begin
            hi_we = (i == 3); wdata = 32'h0;
            start = (i == 5); op = 2'b11;
            @(negedge clk);
        end
        hi_we = 0; start = 0; cancel = 1;
        @(negedge clk);
        cancel = 0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL cancel: busy=%b done=%b, required 0/0", busy, done); end
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin errors++; $display("FAIL cancel_no_done: done seen=%b, required 0", saw_done); end
        checks++;
        if ({hi, lo} !== {32'hA5A5_A5A5, lo_before}) begin errors++; $display("FAIL cancel_hilo: hi=%h lo=%h, required a5a5a5a5/%h", hi, lo, lo_before); end
        cancel = 1; start = 1; op = 2'b00;
        @(negedge clk);
        cancel = 0; start = 0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL cancel_start_idle: busy=%b, required 0", busy); end
    endtask

    task automatic test_async_reset();
        start = 1; op = 2'b00; rs = 32'h1234; rt = 32'h5678;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, hi, lo} !== 66'b0) begin errors++; $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h, required all 0", busy, done, hi, lo); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL post_reset: busy=%b done=%b, required 0/0", busy, done); end
        issue(2'b11, 32'd9, 32'd3);
        wait_result("divu_after_reset", 33);
        checks++;
        if ({hi, lo} !== {32'd0, 32'd3}) begin errors++; $display("FAIL divu_9_3_const: hi=%h lo=%h, required 0/3", hi, lo); end
    endtask

    task automatic test_back_to_back();
        issue(2'b11, 32'd1000, 32'd10);
        wait_result("b2b_first", 33);
        lo_we = 1; wdata = 32'h0000_1111;
        issue(2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFB);
        lo_we = 0;
        checks++;
        if (lo !== 32'h0000_1111) begin errors++; $display("FAIL write_with_start: lo=%h, required 00001111", lo); end
        wait_result("b2b_second", 33);
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, d;
        for (int i = 0; i < 10; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            d = (i == 4) ? 32'h0 : ((i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom);
            issue(o, a, d);
            wait_result($sformatf("random_%0d", i), 33);
        end
    endtask

    initial begin
        test_reset();
        test_writes();
        test_mult();
        test_vectors();
        test_divzero();
        test_busy_inputs();
        test_cancel();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_hilo_controller.md
MULDIV_HILO_CONTROLLER -- requirements
Module: muldiv_hilo_controller

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 32, operand and HI/LO width (even, >=8).
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 SHALL have these ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a multiply/divide.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs  in  DATA_WIDTH  multiplicand / dividend.
- rt  in  DATA_WIDTH  multiplier / divisor.
- cancel  in  1  pipeline flush; abort an in-flight operation.
- hi_we  in  1  MTHI write strobe.
- lo_we  in  1  MTLO write strobe.
- wdata  in  DATA_WIDTH  MTHI/MTLO write data.
- busy  out  1  operation in flight; drives pipeline stall.
- done  out  1  one-cycle completion pulse.
- hi  out  DATA_WIDTH  HI register (MFHI source).
- lo  out  DATA_WIDTH  LO register (MFLO source).

Function
REQ-004 SHALL implement a three-state FSM: IDLE, CALC, FIX.
REQ-005 In IDLE, start=1 at a rising edge SHALL capture op, |rs|, |rt| and the sign flags, clear the iteration counter, and enter CALC.
- |x| is the magnitude for signed ops (MULT/DIV) and x itself for unsigned ops.
REQ-006 CALC SHALL perform exactly one radix-2 iteration per cycle:
- MULT/MULTU: shift-add into a 2*DATA_WIDTH accumulator.
- DIV/DIVU: restoring shift-subtract.
- CALC SHALL leave to FIX after DATA_WIDTH iterations.
REQ-007 FIX SHALL apply sign correction, write HI/LO at the next edge, and return to IDLE.
- Sign correction: negate the product if the operand signs differ; negate the quotient if the signs differ; the remainder takes the dividend's sign.
- Signed ops SHALL use two's-complement modular wrap, including -2^(W-1) operands.
REQ-008 Result placement: multiply {HI,LO} = 2*DATA_WIDTH product; divide LO = quotient, HI = remainder.
REQ-009 Latency: with start accepted at edge E0, busy SHALL be 1 after E0 through E(DATA_WIDTH+1); HI/LO SHALL update and done SHALL be 1 for exactly the cycle after E(DATA_WIDTH+1), with busy=0.
REQ-010 Divide by zero (rt=0, DIV or DIVU): same latency, LO = all ones, HI = rs (unmodified); no other indication.
REQ-011 start while busy=1 SHALL be ignored (no queueing); start in the done cycle SHALL be accepted.
REQ-012 cancel=1 in CALC or FIX SHALL return to IDLE at the next edge, leave HI/LO unchanged, and suppress done.
- cancel in IDLE SHALL have no effect.
- cancel and start together in IDLE: start SHALL be ignored.
REQ-013 hi_we/lo_we SHALL write wdata to HI/LO at the edge only when busy=0; they SHALL be ignored while busy=1.
- hi_we and lo_we together SHALL write both registers.
REQ-014 A write coincident with an accepted start SHALL take effect; the later result overwrites it.
REQ-015 hi/lo SHALL be driven directly from registers; busy and done SHALL be registered, with no combinational path from inputs.

Reset
REQ-016 rst_n=0 SHALL immediately force: FSM=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, internal accumulators=0.
REQ-017 Reset asserted mid-operation SHALL discard the operation with no done pulse; the first start after release SHALL behave per REQ-009.

Verification
REQ-018 MULT rs=7, rt=0xFFFFFFFD (-3), W=32 -> busy for 33 cycles, then done=1 for 1 cycle with HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-019 MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; DIVU 100/7 -> LO=0x0000000E, HI=0x00000002.
REQ-020 DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-021 DIV rs=0x12345678, rt=0 -> after 33 busy cycles, LO=0xFFFFFFFF, HI=0x12345678.
REQ-022 Preload HI=0xA5A5A5A5 via hi_we, start MULT, pulse cancel on busy cycle 10 -> busy=0 next cycle, no done, HI=0xA5A5A5A5.
- In the same run: hi_we during busy has no effect, and start during busy is ignored.
REQ-023 rst_n pulsed low on busy cycle 5 -> busy/done/hi/lo=0 immediately; a new DIVU 9/3 afterwards -> LO=3, HI=0 at the normal latency.
